// File: rtl/compute_dispatch.sv
// Command dispatcher: queues compute commands, owns the BRAM port-B select (mode_compute)
// and sequences start/done handshakes. Optional wait watchdog under `DISPATCH_WATCHDOG_EN.
module compute_dispatch #(
  parameter int ADDR_WIDTH  = 13,
  parameter int LEN_WIDTH   = 23,
  parameter int OP_WIDTH    = 10,
  parameter int AUX_WIDTH   = 16,
  parameter int CMD_DEPTH   = 4,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_unit,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_out,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_const,
  input  logic [OP_WIDTH-1:0]   cmd_opcode,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [AUX_WIDTH-1:0]  cmd_aux,
  output logic [1:0]            mode_compute,
  output logic [ADDR_WIDTH-1:0] addr_a_compute,
  output logic [ADDR_WIDTH-1:0] addr_b_compute,
  output logic [ADDR_WIDTH-1:0] addr_out_compute,
  output logic [ADDR_WIDTH-1:0] addr_const_compute,
  output logic [OP_WIDTH-1:0]   opcode_compute,
  output logic [LEN_WIDTH-1:0]  len_compute,
  output logic [AUX_WIDTH-1:0]  aux_compute,
  output logic                  start_vpu_compute,
  output logic                  start_systolic_compute,
  output logic                  start_vadd_compute,
  input  logic                  vpu_done_compute,
  input  logic                  systolic_done_compute,
  input  logic                  vadd_done_compute,
  output logic                  busy,
  output logic [15:0]           retired_count,
  output logic                  err_timeout,
  input  logic                  err_clr
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam logic [1:0] UNIT_VPU  = 2'b00;
  localparam logic [1:0] UNIT_SYS  = 2'b01;
  localparam logic [1:0] UNIT_VADD = 2'b10;
  localparam logic [1:0] UNIT_NOP  = 2'b11;

  typedef struct packed {
    logic [1:0]            unit;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [ADDR_WIDTH-1:0] addr_const;
    logic [OP_WIDTH-1:0]   opcode;
    logic [LEN_WIDTH-1:0]  len;
    logic [AUX_WIDTH-1:0]  aux;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FIRE, S_WAIT, S_RETIRE} state_e;

  cmd_t             fifo_mem [CMD_DEPTH];
  cmd_t             cmd_in, cmd_q, cmd_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             start_vpu_q, start_vpu_d, start_sys_q, start_sys_d, start_vadd_q, start_vadd_d;
  logic [15:0]      retired_q, retired_d;
  logic             push, pop, full, empty, sel_done, wdog_expired, wdog_hit_q;

  assign cmd_in = '{unit: cmd_unit, addr_a: cmd_addr_a, addr_b: cmd_addr_b, addr_out: cmd_addr_out,
                    addr_const: cmd_addr_const, opcode: cmd_opcode, len: cmd_len, aux: cmd_aux};

  assign full      = (count_q == (PTR_W+1)'(CMD_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == S_IDLE) && !empty;

  // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: queue storage has no reset; the pointers and count alone say which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // Only the latched unit's done is observed; the others are don't-care.
  always_comb begin
    sel_done = 1'b0;
    case (cmd_q.unit)
      UNIT_VPU:  sel_done = vpu_done_compute;
      UNIT_SYS:  sel_done = systolic_done_compute;
      UNIT_VADD: sel_done = vadd_done_compute;
      default:   sel_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_SETUP;
      S_SETUP:  state_d = (cmd_q.unit == UNIT_NOP) ? S_RETIRE : S_FIRE;
      S_FIRE:   state_d = S_WAIT;
      S_WAIT:   if (sel_done || wdog_expired) state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Mode takes the unit at pop (visible from SETUP) and is released only when leaving RETIRE.
  always_comb begin
    cmd_d        = cmd_q;
    mode_d       = mode_q;
    retired_d    = retired_q;
    start_vpu_d  = (state_q == S_SETUP) && (cmd_q.unit == UNIT_VPU);
    start_sys_d  = (state_q == S_SETUP) && (cmd_q.unit == UNIT_SYS);
    start_vadd_d = (state_q == S_SETUP) && (cmd_q.unit == UNIT_VADD);
    if (pop) begin
      cmd_d  = fifo_mem[rd_ptr_q];
      mode_d = fifo_mem[rd_ptr_q].unit;
    end
    if (state_q == S_RETIRE) begin
      mode_d = UNIT_NOP;
      if (!wdog_hit_q) retired_d = retired_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cmd_q        <= '0;
      mode_q       <= UNIT_NOP;
      start_vpu_q  <= 1'b0;
      start_sys_q  <= 1'b0;
      start_vadd_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cmd_q        <= cmd_d;
      mode_q       <= mode_d;
      start_vpu_q  <= start_vpu_d;
      start_sys_q  <= start_sys_d;
      start_vadd_q <= start_vadd_d;
      retired_q    <= retired_d;
    end
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_hit_d, err_q, err_d;

  assign wdog_expired = (state_q == S_WAIT) && !sel_done && (wdog_cnt_q == WDOG_LAST);

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_hit_d = wdog_hit_q;
    err_d      = err_q;
    if (state_q == S_FIRE)      wdog_cnt_d = '0;
    else if (state_q == S_WAIT) wdog_cnt_d = wdog_cnt_q + 16'd1;
    if (wdog_expired)             wdog_hit_d = 1'b1;
    else if (state_q == S_RETIRE) wdog_hit_d = 1'b0;
    if (err_clr)           err_d = 1'b0;
    else if (wdog_expired) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      wdog_hit_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_hit_q <= wdog_hit_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_wdog;
  assign wdog_expired = 1'b0;
  assign wdog_hit_q   = 1'b0;
  assign err_timeout  = 1'b0;
  assign unused_wdog  = &{1'b0, err_clr, 32'(WDOG_CYCLES)};
`endif

  assign busy                   = !empty || (state_q != S_IDLE);
  assign mode_compute           = mode_q;
  assign addr_a_compute         = cmd_q.addr_a;
  assign addr_b_compute         = cmd_q.addr_b;
  assign addr_out_compute       = cmd_q.addr_out;
  assign addr_const_compute     = cmd_q.addr_const;
  assign opcode_compute         = cmd_q.opcode;
  assign len_compute            = cmd_q.len;
  assign aux_compute            = cmd_q.aux;
  assign start_vpu_compute      = start_vpu_q;
  assign start_systolic_compute = start_sys_q;
  assign start_vadd_compute     = start_vadd_q;
  assign retired_count          = retired_q;
endmodule

// File: tb/tb_compute_dispatch.sv
// Directed bench for compute_dispatch: hand-derived cycle-by-cycle expectations, sampled on negedge.
module tb_compute_dispatch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_unit = 2'b00;
  logic [12:0] cmd_addr_a = '0, cmd_addr_b = '0, cmd_addr_out = '0, cmd_addr_const = '0;
  logic [9:0]  cmd_opcode = '0;
  logic [22:0] cmd_len = '0;
  logic [15:0] cmd_aux = '0;
  logic [1:0]  mode_compute;
  logic [12:0] addr_a_compute, addr_b_compute, addr_out_compute, addr_const_compute;
  logic [9:0]  opcode_compute;
  logic [22:0] len_compute;
  logic [15:0] aux_compute;
  logic        start_vpu_compute, start_systolic_compute, start_vadd_compute;
  logic        vpu_done, sys_done, vadd_done;
  logic        busy;
  logic [15:0] retired_count;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  logic man_vpu = 1'b0, man_sys = 1'b0, man_vadd = 1'b0;
  logic auto_vpu = 1'b0, auto_sys = 1'b0, auto_vadd = 1'b0;
  logic auto_en = 1'b0;
  logic resp_pend = 1'b0;
  logic [1:0] resp_unit = 2'b00;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int start_multi = 0;
  int start_cyc[$];
  logic [9:0] start_op[$];

  assign vpu_done  = man_vpu  | auto_vpu;
  assign sys_done  = man_sys  | auto_sys;
  assign vadd_done = man_vadd | auto_vadd;

  compute_dispatch #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_out(cmd_addr_out),
    .cmd_addr_const(cmd_addr_const), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_aux(cmd_aux),
    .mode_compute(mode_compute),
    .addr_a_compute(addr_a_compute), .addr_b_compute(addr_b_compute),
    .addr_out_compute(addr_out_compute), .addr_const_compute(addr_const_compute),
    .opcode_compute(opcode_compute), .len_compute(len_compute), .aux_compute(aux_compute),
    .start_vpu_compute(start_vpu_compute), .start_systolic_compute(start_systolic_compute),
    .start_vadd_compute(start_vadd_compute),
    .vpu_done_compute(vpu_done), .systolic_done_compute(sys_done), .vadd_done_compute(vadd_done),
    .busy(busy), .retired_count(retired_count), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records every start pulse; when auto_en is set, answers it with a done in the first WAIT cycle.
  always @(negedge clk) begin
    auto_vpu  = 1'b0;
    auto_sys  = 1'b0;
    auto_vadd = 1'b0;
    if (resp_pend) begin
      auto_vpu  = (resp_unit == 2'b00);
      auto_sys  = (resp_unit == 2'b01);
      auto_vadd = (resp_unit == 2'b10);
      resp_pend = 1'b0;
    end
    if (start_vpu_compute || start_systolic_compute || start_vadd_compute) begin
      start_cyc.push_back(cyc);
      start_op.push_back(opcode_compute);
      if ((int'(start_vpu_compute) + int'(start_systolic_compute) + int'(start_vadd_compute)) != 1)
        start_multi++;
      if (auto_en) begin
        resp_pend = 1'b1;
        resp_unit = start_vpu_compute ? 2'b00 : (start_systolic_compute ? 2'b01 : 2'b10);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    {man_vpu, man_sys, man_vadd, err_clr, auto_en} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; the command is accepted on the next posedge and the task returns one negedge later.
  task automatic push(input logic [1:0] unit, input logic [9:0] op,
                      input logic [12:0] a, input logic [12:0] b, input logic [12:0] o);
    check("push_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_unit = unit;
    cmd_opcode = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_addr_out = o;
    cmd_addr_const = a + 13'h7;
    cmd_len = {13'd0, op};
    cmd_aux = {6'd0, op};
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic logic [2:0] starts();
    return {start_vadd_compute, start_systolic_compute, start_vpu_compute};
  endfunction

  initial begin
    int sz;
    apply_reset();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_mode", mode_compute, 2'b11);
    check("rst_starts", starts(), 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_retired", retired_count, 16'd0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_addr_a", addr_a_compute, 13'h0);
    check("rst_len", len_compute, 23'h0);

    // Systolic command, done returned 8 cycles after the start cycle.
    push(2'b01, 10'h0A3, 13'h010, 13'h020, 13'h100);
    check("t1_idle_mode", mode_compute, 2'b11);
    check("t1_busy", busy, 1'b1);
    step();
    check("t1_setup_mode", mode_compute, 2'b01);
    check("t1_setup_nostart", starts(), 3'b000);
    check("t1_addr_a", addr_a_compute, 13'h010);
    check("t1_addr_b", addr_b_compute, 13'h020);
    check("t1_addr_out", addr_out_compute, 13'h100);
    check("t1_addr_const", addr_const_compute, 13'h017);
    check("t1_opcode", opcode_compute, 10'h0A3);
    check("t1_len", len_compute, 23'h0A3);
    check("t1_aux", aux_compute, 16'h0A3);
    step();
    check("t1_fire_start", starts(), 3'b010);
    check("t1_fire_mode", mode_compute, 2'b01);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t1_wait%0d_start", i), starts(), 3'b000);
      check($sformatf("t1_wait%0d_mode", i), mode_compute, 2'b01);
    end
    step();
    man_sys = 1'b1;
    step();
    man_sys = 1'b0;
    check("t1_retire_mode", mode_compute, 2'b01);
    check("t1_retire_count", retired_count, 16'd0);
    step();
    check("t1_idle_mode_back", mode_compute, 2'b11);
    check("t1_retired", retired_count, 16'd1);
    check("t1_busy_end", busy, 1'b0);
    check("t1_err", err_timeout, 1'b0);

    // Five back-to-back VPU commands: FIFO fills, all retire in order at the minimum start spacing.
    apply_reset();
    start_cyc.delete();
    start_op.delete();
    auto_en = 1'b1;
    for (int i = 1; i <= 5; i++) push(2'b00, 10'(i), 13'(i), 13'(i + 16), 13'(i + 32));
    check("t2_full_ready", cmd_ready, 1'b0);
    for (int k = 0; k < 300 && !(retired_count == 16'd5 && !busy); k++) step();
    #1;
    check("t2_retired", retired_count, 16'd5);
    check("t2_busy", busy, 1'b0);
    check("t2_ready", cmd_ready, 1'b1);
    check("t2_nstarts", start_cyc.size(), 5);
    for (int i = 0; i < start_op.size(); i++) check($sformatf("t2_order%0d", i), start_op[i], 10'(i + 1));
    for (int i = 1; i < start_cyc.size(); i++)
      check($sformatf("t2_gap%0d", i), start_cyc[i] - start_cyc[i-1], 5);
    auto_en = 1'b0;

    // VPU command: done during SETUP/FIRE and foreign dones during WAIT are ignored.
    apply_reset();
    push(2'b00, 10'h021, 13'h040, 13'h041, 13'h042);
    step();
    man_vpu = 1'b1;
    step();
    check("t3_fire_start", starts(), 3'b001);
    step();
    man_vpu = 1'b0;
    man_vadd = 1'b1;
    man_sys = 1'b1;
    step();
    man_vadd = 1'b0;
    man_sys = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold%0d_mode", i), mode_compute, 2'b00);
      check($sformatf("t3_hold%0d_retired", i), retired_count, 16'd0);
      step();
    end
    man_vpu = 1'b1;
    step();
    man_vpu = 1'b0;
    check("t3_retire_mode", mode_compute, 2'b00);
    check("t3_retire_count", retired_count, 16'd0);
    step();
    check("t3_idle_mode", mode_compute, 2'b11);
    check("t3_retired", retired_count, 16'd1);

    // NOP: no start, mode stays idle, retires and is back in IDLE three cycles after the pop cycle.
    #1 sz = start_cyc.size();
    push(2'b11, 10'h044, 13'h050, 13'h051, 13'h052);
    check("t4_pop_mode", mode_compute, 2'b11);
    step();
    check("t4_setup_mode", mode_compute, 2'b11);
    check("t4_setup_starts", starts(), 3'b000);
    check("t4_opcode", opcode_compute, 10'h044);
    step();
    check("t4_retire_mode", mode_compute, 2'b11);
    check("t4_retire_starts", starts(), 3'b000);
    check("t4_retire_busy", busy, 1'b1);
    step();
    check("t4_retired", retired_count, 16'd2);
    check("t4_busy", busy, 1'b0);
    #1 check("t4_no_start", start_cyc.size(), sz);

    // Reset during WAIT of a vadd with a second command queued.
    push(2'b10, 10'h055, 13'h300, 13'h301, 13'h302);
    push(2'b00, 10'h056, 13'h310, 13'h311, 13'h312);
    check("t5_setup_mode", mode_compute, 2'b10);
    step();
    check("t5_fire_start", starts(), 3'b100);
    step();
    rst_n = 1'b0;
    #1;
    sz = start_cyc.size();
    check("t5_rst_mode", mode_compute, 2'b11);
    check("t5_rst_starts", starts(), 3'b000);
    check("t5_rst_addr_a", addr_a_compute, 13'h0);
    check("t5_rst_opcode", opcode_compute, 10'h0);
    check("t5_rst_aux", aux_compute, 16'h0);
    check("t5_rst_retired", retired_count, 16'd0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    #1;
    check("t5_no_restart", start_cyc.size(), sz);
    check("t5_busy", busy, 1'b0);
    check("t5_mode", mode_compute, 2'b11);
    check("t5_retired", retired_count, 16'd0);
    check("t5_err", err_timeout, 1'b0);

`ifdef DISPATCH_WATCHDOG_EN
    // VPU command never completes: watchdog retires it after 16 WAIT cycles, queued vadd proceeds.
    apply_reset();
    push(2'b00, 10'h061, 13'h400, 13'h401, 13'h402);
    push(2'b10, 10'h062, 13'h410, 13'h411, 13'h412);
    step();
    check("t6_fire_start", starts(), 3'b001);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("t6_wait%0d_err", i), err_timeout, 1'b0);
    end
    step();
    check("t6_retire_err", err_timeout, 1'b1);
    check("t6_retire_mode", mode_compute, 2'b00);
    check("t6_retire_count", retired_count, 16'd0);
    step();
    check("t6_idle_mode", mode_compute, 2'b11);
    check("t6_idle_count", retired_count, 16'd0);
    auto_en = 1'b1;
    for (int k = 0; k < 100 && busy; k++) step();
    #1;
    check("t6_next_retired", retired_count, 16'd1);
    check("t6_next_op", start_op[start_op.size()-1], 10'h062);
    check("t6_err_sticky", err_timeout, 1'b1);
    auto_en = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t6_err_clr", err_timeout, 1'b0);
`endif

    check("one_start_at_a_time", start_multi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "bench timeout");
  end
endmodule
